// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 16x oversampling, majority-of-3 bit decisions,
// optional parity, one or two stop bits, break detection and a one-word
// holding register with valid/ready handshake and overrun reporting.
module uart_rx_param #(
    parameter int unsigned FREQUENCY = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 rx_ready,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_break,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int unsigned DIV   = (FREQUENCY + 8 * BAUD) / (16 * BAUD);
    localparam int unsigned DIV_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    generate
        if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
            $error("uart_rx_param: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop, StBrk} state_t;

    state_t               r_state, w_state_next;
    logic [1:0]           r_sync;
    logic                 r_rxd_prev;
    logic [DIV_W-1:0]     r_div, w_div_next;
    logic [3:0]           r_cnt, w_cnt_next;
    logic [3:0]           r_bit, w_bit_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic                 r_s7, w_s7_next;
    logic                 r_s8, w_s8_next;
    logic                 r_par_err, w_par_err_next;
    logic                 r_frm_err, w_frm_err_next;
    logic                 w_done, w_brk, w_frm_final;

    logic                 r_valid, r_par_flag, r_frm_flag, r_brk_flag, r_overrun;
    logic [DATA_BITS-1:0] r_data;

    logic w_rxd, w_fall, w_tick, w_sample, w_maj, w_par_x;

    assign w_rxd    = r_sync[1];
    assign w_fall   = r_rxd_prev & ~w_rxd;
    assign w_tick   = (r_div == DIV_LAST);
    // Bit decision happens on tick 9, once ticks 7 and 8 have been captured.
    assign w_sample = w_tick && (r_cnt == 4'd9);
    assign w_maj    = (r_s7 & r_s8) | (r_s7 & w_rxd) | (r_s8 & w_rxd);
    assign w_par_x  = (^r_shift) ^ w_maj;

    // Synchronizer, edge-detect history and receive FSM/datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync     <= 2'b11;
            r_rxd_prev <= 1'b1;
            r_state    <= StIdle;
            r_div      <= '0;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_s7       <= 1'b1;
            r_s8       <= 1'b1;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], rxd};
            r_rxd_prev <= w_rxd;
            r_state    <= w_state_next;
            r_div      <= w_div_next;
            r_cnt      <= w_cnt_next;
            r_bit      <= w_bit_next;
            r_shift    <= w_shift_next;
            r_s7       <= w_s7_next;
            r_s8       <= w_s8_next;
            r_par_err  <= w_par_err_next;
            r_frm_err  <= w_frm_err_next;
        end
    end

    // Next-state logic: oversample timing, bit decisions and frame completion.
    always_comb begin
        w_state_next   = r_state;
        w_div_next     = r_div;
        w_cnt_next     = r_cnt;
        w_bit_next     = r_bit;
        w_shift_next   = r_shift;
        w_s7_next      = r_s7;
        w_s8_next      = r_s8;
        w_par_err_next = r_par_err;
        w_frm_err_next = r_frm_err;
        w_done         = 1'b0;
        w_brk          = 1'b0;
        w_frm_final    = r_frm_err;

        // Timing is held at zero while waiting so sampling phase tracks the start edge.
        if (r_state == StIdle || r_state == StBrk) begin
            w_div_next = '0;
            w_cnt_next = '0;
        end else if (w_tick) begin
            w_div_next = '0;
            w_cnt_next = r_cnt + 4'd1;
            if (r_cnt == 4'd7) w_s7_next = w_rxd;
            if (r_cnt == 4'd8) w_s8_next = w_rxd;
        end else begin
            w_div_next = r_div + 1'b1;
        end

        case (r_state)
            StIdle: begin
                if (w_fall) begin
                    w_state_next   = StStart;
                    w_bit_next     = '0;
                    w_par_err_next = 1'b0;
                    w_frm_err_next = 1'b0;
                end
            end
            StStart: begin
                if (w_sample) begin
                    w_bit_next   = '0;
                    w_state_next = w_maj ? StIdle : StData;
                end
            end
            StData: begin
                if (w_sample) begin
                    w_shift_next = {w_maj, r_shift[DATA_BITS-1:1]};
                    if (r_bit == LAST_DATA) begin
                        w_bit_next   = '0;
                        w_state_next = (PARITY != 0) ? StPar : StStop;
                    end else begin
                        w_bit_next = r_bit + 4'd1;
                    end
                end
            end
            StPar: begin
                if (w_sample) begin
                    w_par_err_next = (PARITY == 2) ? ~w_par_x : w_par_x;
                    w_bit_next     = '0;
                    w_state_next   = StStop;
                end
            end
            StStop: begin
                if (w_sample) begin
                    if (!w_maj) w_frm_err_next = 1'b1;
                    if (r_bit == LAST_STOP) begin
                        w_done      = 1'b1;
                        w_frm_final = r_frm_err | ~w_maj;
                        if (r_shift == '0 && !w_maj) begin
                            w_brk        = 1'b1;
                            w_state_next = StBrk;
                        end else begin
                            w_state_next = StIdle;
                        end
                    end else begin
                        w_bit_next = r_bit + 4'd1;
                    end
                end
            end
            StBrk: begin
                if (w_rxd) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Holding register: load on completion if free or being consumed, else flag overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_par_flag <= 1'b0;
            r_frm_flag <= 1'b0;
            r_brk_flag <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (w_done) begin
            if (!r_valid || rx_ready) begin
                r_valid    <= 1'b1;
                r_data     <= r_shift;
                r_par_flag <= r_par_err;
                r_frm_flag <= w_frm_final;
                r_brk_flag <= w_brk;
                r_overrun  <= 1'b0;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && rx_ready) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign rx_valid      = r_valid;
    assign rx_data       = r_data;
    assign rx_parity_err = r_par_flag;
    assign rx_frame_err  = r_frm_flag;
    assign rx_break      = r_brk_flag;
    assign rx_overrun    = r_overrun;
    assign rx_busy       = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances (8N1, 8E1, 8N2) at
// 1.6 MHz / 10 kbaud, 160 clocks per bit.
module tb_uart_rx_param;

    localparam int unsigned FREQ     = 1600000;
    localparam int unsigned RATE     = 10000;
    localparam int          BIT_CLKS = 160;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd_a = 1'b1, rxd_b = 1'b1, rxd_c = 1'b1;
    logic ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;

    logic       a_valid, a_perr, a_frm, a_brk, a_ovr, a_busy;
    logic [7:0] a_data;
    logic       b_valid, b_perr, b_frm, b_brk, b_ovr, b_busy;
    logic [7:0] b_data;
    logic       c_valid, c_perr, c_frm, c_brk, c_ovr, c_busy;
    logic [7:0] c_data;

    int n_tests = 0;
    int n_fail  = 0;

    int         a_cnt = 0, a_vcyc = 0, b_cnt = 0, c_cnt = 0;
    logic [7:0] a_dcap = '0, b_dcap = '0, c_dcap = '0;
    logic [3:0] a_fcap = '0;
    logic       b_perr_cap = 1'b0, c_frm_cap = 1'b0, c_brk_cap = 1'b0;

    always #5 clk = ~clk;

    uart_rx_param #(.FREQUENCY(FREQ), .BAUD(RATE), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    u_dut_a (
        .clk(clk), .rst(rst), .rxd(rxd_a), .rx_ready(ready_a), .rx_valid(a_valid),
        .rx_data(a_data), .rx_parity_err(a_perr), .rx_frame_err(a_frm), .rx_break(a_brk),
        .rx_overrun(a_ovr), .rx_busy(a_busy)
    );

    uart_rx_param #(.FREQUENCY(FREQ), .BAUD(RATE), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
    u_dut_b (
        .clk(clk), .rst(rst), .rxd(rxd_b), .rx_ready(ready_b), .rx_valid(b_valid),
        .rx_data(b_data), .rx_parity_err(b_perr), .rx_frame_err(b_frm), .rx_break(b_brk),
        .rx_overrun(b_ovr), .rx_busy(b_busy)
    );

    uart_rx_param #(.FREQUENCY(FREQ), .BAUD(RATE), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2))
    u_dut_c (
        .clk(clk), .rst(rst), .rxd(rxd_c), .rx_ready(ready_c), .rx_valid(c_valid),
        .rx_data(c_data), .rx_parity_err(c_perr), .rx_frame_err(c_frm), .rx_break(c_brk),
        .rx_overrun(c_ovr), .rx_busy(c_busy)
    );

    // Handshake monitors; inputs change just after posedge, so negedge sees settled values.
    always @(negedge clk) begin
        if (a_valid) a_vcyc <= a_vcyc + 1;
        if (a_valid && ready_a) begin
            a_cnt  <= a_cnt + 1;
            a_dcap <= a_data;
            a_fcap <= {a_perr, a_frm, a_brk, a_ovr};
        end
        if (b_valid && ready_b) begin
            b_cnt      <= b_cnt + 1;
            b_dcap     <= b_data;
            b_perr_cap <= b_perr;
        end
        if (c_valid && ready_c) begin
            c_cnt     <= c_cnt + 1;
            c_dcap    <= c_data;
            c_frm_cap <= c_frm;
            c_brk_cap <= c_brk;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int sel, input logic v);
        case (sel)
            0:       rxd_a = v;
            1:       rxd_b = v;
            default: rxd_c = v;
        endcase
    endtask

    // Drive n bit periods, bits[0] first, then leave the line idle high.
    task automatic send_bits(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_line(sel, bits[i]);
            tick(BIT_CLKS);
        end
        set_line(sel, 1'b1);
    endtask

    int n0;
    int v0;

    initial begin
        tick(4);
        @(negedge clk);
        check("rst_valid", a_valid, 0);
        check("rst_data", a_data, 0);
        check("rst_busy", a_busy, 0);
        check("rst_flags", {a_perr, a_frm, a_brk, a_ovr}, 0);
        tick(1);
        rst = 1'b0;
        tick(20);

        // 8N1 0xA5
        n0 = a_cnt;
        v0 = a_vcyc;
        send_bits(0, {1'b1, 8'hA5, 1'b0}, 10);
        tick(20);
        @(negedge clk);
        check("a5_count", a_cnt, n0 + 1);
        check("a5_valid_cycles", a_vcyc, v0 + 1);
        check("a5_data", a_dcap, 8'hA5);
        check("a5_flags", a_fcap, 4'h0);

        // Even parity: 0x03 has even ones, so parity bit 1 is wrong, 0 is right
        send_bits(1, {1'b1, 1'b1, 8'h03, 1'b0}, 11);
        tick(20);
        @(negedge clk);
        check("par1_data", b_dcap, 8'h03);
        check("par1_err", b_perr_cap, 1);
        send_bits(1, {1'b1, 1'b0, 8'h03, 1'b0}, 11);
        tick(20);
        @(negedge clk);
        check("par0_err", b_perr_cap, 0);
        check("par_count", b_cnt, 2);

        // Two stop bits, second one low
        send_bits(2, {1'b0, 1'b1, 8'h5A, 1'b0}, 12);
        tick(20);
        @(negedge clk);
        check("stop2_data", c_dcap, 8'h5A);
        check("stop2_frame_err", c_frm_cap, 1);
        check("stop2_break", c_brk_cap, 0);
        check("stop2_count", c_cnt, 1);

        // False start: ~80 clocks low
        n0 = a_cnt;
        set_line(0, 1'b0);
        tick(40);
        @(negedge clk);
        check("fs_busy_during", a_busy, 1);
        tick(40);
        set_line(0, 1'b1);
        tick(300);
        @(negedge clk);
        check("fs_busy_after", a_busy, 0);
        check("fs_no_delivery", a_cnt, n0);
        send_bits(0, {1'b1, 8'h11, 1'b0}, 10);
        tick(20);
        @(negedge clk);
        check("fs_next_count", a_cnt, n0 + 1);
        check("fs_next_data", a_dcap, 8'h11);

        // Overrun: hold off the consumer across two frames
        tick(1);
        ready_a = 1'b0;
        send_bits(0, {1'b1, 8'h01, 1'b0}, 10);
        tick(20);
        send_bits(0, {1'b1, 8'h02, 1'b0}, 10);
        tick(20);
        @(negedge clk);
        check("ovr_valid", a_valid, 1);
        check("ovr_data", a_data, 8'h01);
        check("ovr_flag", a_ovr, 1);
        tick(1);
        ready_a = 1'b1;
        tick(1);
        ready_a = 1'b0;
        @(negedge clk);
        check("ovr_consumed_valid", a_valid, 0);
        check("ovr_consumed_flag", a_ovr, 0);
        check("ovr_consumed_data", a_dcap, 8'h01);
        tick(1);
        ready_a = 1'b1;

        // Break: line low for 2000 clocks
        n0 = a_cnt;
        set_line(0, 1'b0);
        tick(2000);
        @(negedge clk);
        check("brk_busy_low", a_busy, 1);
        check("brk_count", a_cnt, n0 + 1);
        check("brk_data", a_dcap, 8'h00);
        check("brk_flags", a_fcap, 4'b0110);
        tick(1);
        set_line(0, 1'b1);
        tick(20);
        @(negedge clk);
        check("brk_busy_high", a_busy, 0);
        check("brk_single", a_cnt, n0 + 1);

        // Reset during bit 4 of a 0x3C frame
        n0 = a_cnt;
        send_bits(0, {4'hC, 1'b0}, 5);
        tick(80);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_busy", a_busy, 0);
        check("rstmid_valid", a_valid, 0);
        tick(2000);
        @(negedge clk);
        check("rstmid_no_delivery", a_cnt, n0);
        send_bits(0, {1'b1, 8'h5A, 1'b0}, 10);
        tick(20);
        @(negedge clk);
        check("rstmid_resume_count", a_cnt, n0 + 1);
        check("rstmid_resume_data", a_dcap, 8'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
